// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle for the shared comparator arbiter.
// Master: requesters plus response consumer. Slave: the arbiter.
interface cmp_share_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int IDW   = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_g;
   logic                  rsp_e;
   logic                  rsp_l;
   logic                  rsp_err;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id,
      input  rsp_g, rsp_e, rsp_l, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id,
      output rsp_g, rsp_e, rsp_l, rsp_err
   );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one magnitude comparator among NREQ requesters.
// Operands are registered into the comparator; the result returns with its ID.
module cmp_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int IDW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   cmp_share_arbiter_if.slave bus,
   output logic [WIDTH-1:0] cmp_a,
   output logic [WIDTH-1:0] cmp_b,
   input  logic             cmp_g,
   input  logic             cmp_e,
   input  logic             cmp_l,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      RESP
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [IDW-1:0] rr_q;
   logic [IDW-1:0] grant;
   logic           grant_vld;
   logic [IDW:0]   scan;
   logic           onehot;

   logic           rsp_valid_q;
   logic [IDW-1:0] rsp_id_q;
   logic           rsp_g_q;
   logic           rsp_e_q;
   logic           rsp_l_q;
   logic           rsp_err_q;

   // Search for the first pending request at or above rr_q, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      scan      = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, rr_q} + (IDW+1)'(k);
         if (scan >= (IDW+1)'(NREQ))
            scan = scan - (IDW+1)'(NREQ);
         if (!grant_vld && bus.req_valid[scan[IDW-1:0]]) begin
            grant_vld = 1'b1;
            grant     = scan[IDW-1:0];
         end
      end
   end

   // One-hot accept pulse, only while idle.
   always_comb begin
      bus.req_ready = '0;
      if (state_q == IDLE && grant_vld)
         bus.req_ready = NREQ'(1) << grant;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (grant_vld) state_d = EVAL;
         EVAL: state_d = RESP;
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign onehot = (cmp_g & ~cmp_e & ~cmp_l)
                 | (~cmp_g & cmp_e & ~cmp_l)
                 | (~cmp_g & ~cmp_e & cmp_l);

   // Operand capture, result capture and response/pointer bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q        <= '0;
         cmp_a       <= '0;
         cmp_b       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_g_q     <= 1'b0;
         rsp_e_q     <= 1'b0;
         rsp_l_q     <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  cmp_a    <= bus.req_a[int'(grant)*WIDTH +: WIDTH];
                  cmp_b    <= bus.req_b[int'(grant)*WIDTH +: WIDTH];
                  rsp_id_q <= grant;
               end
            end
            EVAL: begin
               rsp_g_q     <= cmp_g;
               rsp_e_q     <= cmp_e;
               rsp_l_q     <= cmp_l;
               rsp_err_q   <= ~onehot;
               rsp_valid_q <= 1'b1;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  if (rsp_id_q == IDW'(NREQ-1))
                     rr_q <= '0;
                  else
                     rr_q <= rsp_id_q + IDW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_g     = rsp_g_q;
   assign bus.rsp_e     = rsp_e_q;
   assign bus.rsp_l     = rsp_l_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter with an external comparator
// model whose outputs can be overridden to inject faults.
module tb_cmp_share_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] cmp_a;
   logic [WIDTH-1:0] cmp_b;
   logic             cmp_g;
   logic             cmp_e;
   logic             cmp_l;
   logic             busy;

   logic             f_en;
   logic [2:0]       f_gel;

   int checks = 0;
   int errors = 0;

   cmp_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .cmp_a (cmp_a),
      .cmp_b (cmp_b),
      .cmp_g (cmp_g),
      .cmp_e (cmp_e),
      .cmp_l (cmp_l),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   assign cmp_g = f_en ? f_gel[2] : (cmp_a > cmp_b);
   assign cmp_e = f_en ? f_gel[1] : (cmp_a == cmp_b);
   assign cmp_l = f_en ? f_gel[0] : (cmp_a < cmp_b);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_out();
      return {14'd0, bus.req_ready, cmp_a, cmp_b, bus.rsp_valid,
              bus.rsp_id, bus.rsp_g, bus.rsp_e, bus.rsp_l,
              bus.rsp_err, busy};
   endfunction

   function automatic logic [2:0] gel();
      return {bus.rsp_g, bus.rsp_e, bus.rsp_l};
   endfunction

   // Issue one request from requester i and consume its response.
   task automatic single(input int i, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] eg,
                         input logic ee);
      bus.req_a[i*WIDTH +: WIDTH] = a;
      bus.req_b[i*WIDTH +: WIDTH] = b;
      bus.req_valid = NREQ'(1) << i;
      #1;
      chk("s_ready", bus.req_ready, NREQ'(1) << i);
      step();
      chk("s_cmp_a", cmp_a, a);
      chk("s_cmp_b", cmp_b, b);
      chk("s_eval_rv", bus.rsp_valid, 0);
      chk("s_eval_rdy", bus.req_ready, 0);
      bus.req_valid = '0;
      step();
      chk("s_rv", bus.rsp_valid, 1);
      chk("s_id", bus.rsp_id, i);
      chk("s_gel", gel(), eg);
      chk("s_err", bus.rsp_err, ee);
      bus.rsp_ready = 1'b1;
      step();
      chk("s_done", {bus.rsp_valid, busy}, 0);
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      f_en          = 1'b0;
      f_gel         = 3'b000;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      #2;
      chk("rst_out", all_out(), 0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("idle_rdy", bus.req_ready, 0);
         chk("idle_busy", busy, 0);
      end

      // Single requests.
      single(0, 4'd9, 4'd3, 3'b100, 1'b0);
      single(0, 4'd5, 4'd5, 3'b010, 1'b0);
      single(0, 4'd2, 4'd14, 3'b001, 1'b0);

      // Fresh pointer for round-robin.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.req_a     = {4'd7, 4'd6, 4'd5, 4'd4};
      bus.req_b     = {4'd5, 4'd5, 4'd5, 4'd5};
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("rr_ready", bus.req_ready, NREQ'(1) << g);
         step();
         chk("rr_eval_rdy", bus.req_ready, 0);
         step();
         chk("rr_rv", bus.rsp_valid, 1);
         chk("rr_id", bus.rsp_id, g);
         chk("rr_gel", gel(), (g == 0) ? 3'b001 :
                              (g == 1) ? 3'b010 : 3'b100);
         step();
      end
      bus.req_valid = 4'b0101;
      for (int n = 0; n < 2; n++) begin
         #1;
         chk("rr5_ready", bus.req_ready, (n == 0) ? 4'b0001 : 4'b0100);
         step();
         step();
         chk("rr5_id", bus.rsp_id, (n == 0) ? 0 : 2);
         step();
      end

      // rsp_ready while idle is ignored; pointer now 3.
      bus.req_valid = '0;
      step();
      chk("ign_rv", {bus.rsp_valid, busy}, 0);

      // Backpressure.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      #1;
      chk("bp_ready", bus.req_ready, 4'b1000);
      step();
      step();
      chk("bp_rv", bus.rsp_valid, 1);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_hold", {bus.rsp_valid, bus.rsp_id, gel(),
                         bus.req_ready}, {1'b1, 2'd3, 3'b100, 4'b0000});
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("bp_idle", {bus.rsp_valid, busy}, 0);
      chk("bp_next", bus.req_ready, 4'b0001);
      bus.req_valid = '0;
      step();

      // Comparator fault: g and e together.
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = '0;
      f_en  = 1'b1;
      f_gel = 3'b110;
      step();
      chk("f1_gel", gel(), 3'b110);
      chk("f1_err", bus.rsp_err, 1);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;

      // Comparator fault: nothing asserted.
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = '0;
      f_gel = 3'b000;
      step();
      chk("f0_gel", gel(), 3'b000);
      chk("f0_err", bus.rsp_err, 1);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      f_en = 1'b0;

      // Reset in EVAL.
      bus.req_a[2*WIDTH +: WIDTH] = 4'd11;
      bus.req_valid = 4'b0100;
      step();
      chk("rm_busy", busy, 1);
      bus.req_valid = '0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rm_out", all_out(), 0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rm_norsp", {bus.rsp_valid, busy}, 0);
      end
      bus.req_valid = 4'b1010;
      #1;
      chk("rm_grant", bus.req_ready, 4'b0010);
      step();
      bus.req_valid = '0;
      step();
      chk("rm_id", bus.rsp_id, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
